dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit data words held.
REQ-002 Parameter WAIT_STATES, default 1: cycles between request capture and response (0..15).
REQ-003 Parameter CHECK_ADDR, default 100: byte address of the result mailbox word.
REQ-004 Parameter CHECK_DATA, default 7: mailbox value signalling a passing program.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 MemWrite  input  1  processor write request; held until Ready.
REQ-008 MemRead  input  1  processor read request; held until Ready.
REQ-009 DataAdr  input  32  byte address of the access.
REQ-010 WriteData  input  32  store data.
REQ-011 ReadData  output  32  load data; valid while Ready=1.
REQ-012 Ready  output  1  one-cycle access-complete strobe.
REQ-013 Done  output  1  sticky; mailbox write seen.
REQ-014 Pass  output  1  sticky; first mailbox write carried CHECK_DATA.
REQ-015 ErrFlag  output  1  sticky; misaligned or out-of-range access seen.
REQ-016 WrCount  output  16  committed write count, saturating at 16'hFFFF.

Function
REQ-017 FSM states IDLE, WAIT, RESP; IDLE is the only state that samples requests.
REQ-018 IDLE with MemWrite|MemRead=1 at an edge: capture DataAdr, WriteData, type; go WAIT with counter=WAIT_STATES-1, or RESP if WAIT_STATES=0.
REQ-019 WAIT: decrement counter each cycle; at counter=0 go RESP.
REQ-020 RESP: Ready=1 for exactly one cycle, then IDLE; Ready=0 in all other states.
REQ-021 Request at edge k -> Ready high during cycle k+WAIT_STATES+1; back-to-back access period WAIT_STATES+2 cycles.
REQ-022 Input changes after capture are ignored until return to IDLE.
REQ-023 MemWrite and MemRead both high: treated as write only; ReadData=0 in RESP.
REQ-024 Word index = captured DataAdr[log2(DEPTH)+1:2].
REQ-025 Write committed to RAM on the edge entering RESP; read data taken from RAM on that edge and held in ReadData through RESP.
REQ-026 ReadData returns to 0 on leaving RESP.
REQ-027 Misaligned (DataAdr[1:0]!=0) or out-of-range (DataAdr>=4*DEPTH) access: write dropped, read returns 0, Ready still issued, ErrFlag set on entering RESP.
REQ-028 Committed write increments WrCount by 1; dropped writes do not count.
REQ-029 Committed write to CHECK_ADDR with Done=0: Done<=1, Pass<=(WriteData==CHECK_DATA); later mailbox writes update RAM only.
REQ-030 Read immediately after write to same word returns new data.

Reset
REQ-031 reset low asynchronously forces: IDLE, Ready=0, ReadData=0, Done=0, Pass=0, ErrFlag=0, WrCount=0, wait counter=0.
REQ-032 RAM contents are not reset; reads of unwritten words are undefined.
REQ-033 reset asserted in WAIT: pending write discarded, no Ready issued; release returns to IDLE sampling on the first rising edge after deassertion.

Verification
REQ-034 WAIT_STATES=1; write 0x12345678 to 0x20 then read 0x20 -> Ready two cycles after each request, ReadData=0x12345678, WrCount=1.
REQ-035 Write 7 to 100 -> Done=1, Pass=1; then write 9 to 100 -> Pass stays 1, read 100 returns 9.
REQ-036 First mailbox write 5 to 100 -> Done=1, Pass=0; ErrFlag=0.
REQ-037 Write to 0x22 and read of 0x400 -> Ready issued both, no RAM change, read returns 0, ErrFlag=1, WrCount unchanged.
REQ-038 Write 0xAA to 0x10, reset pulsed low in WAIT -> Ready never asserted, all outputs 0, later read of 0x10 not 0xAA-guaranteed.
REQ-039 WAIT_STATES=0 and 3 builds: Ready at cycle k+1 and k+4 respectively for a request sampled at edge k.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data memory responder for a processor under test: one access at a time,
// a fixed wait-state latency, and sticky pass/fail/error flags fed by a result mailbox word.
module dmem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 1,
   parameter int CHECK_ADDR  = 100,
   parameter int CHECK_DATA  = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Done,
   output logic        Pass,
   output logic        ErrFlag,
   output logic [15:0] WrCount,
   output logic [1:0]  state_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [31:0] ADR_LIMIT = 32'(4 * DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   adr_q, wdata_q;
   logic          wr_q, rd_q;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   acc_adr, acc_wdata;
   logic          acc_wr, acc_rd, acc_bad, enter_resp, do_write;
   logic [AW-1:0] acc_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (MemWrite || MemRead) begin
            if (WAIT_STATES == 0) state_d = S_RESP;
            else begin
               state_d = S_WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
                 else cnt_d = cnt_q - 4'd1;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Ready   = (state_q == S_RESP);
      state_o = state_q;
   end

   // With zero wait states the access completes on the capture edge itself,
   // so the live inputs stand in for the captured request while in IDLE.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_adr   = DataAdr;
         acc_wdata = WriteData;
         acc_wr    = MemWrite;
         acc_rd    = MemRead & ~MemWrite;
      end else begin
         acc_adr   = adr_q;
         acc_wdata = wdata_q;
         acc_wr    = wr_q;
         acc_rd    = rd_q;
      end
      acc_bad    = (acc_adr[1:0] != 2'b00) || (acc_adr >= ADR_LIMIT);
      acc_idx    = acc_adr[AW+1:2];
      enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
      do_write   = reset && enter_resp && acc_wr && !acc_bad;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         adr_q    <= 32'd0;
         wdata_q  <= 32'd0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         ReadData <= 32'd0;
         Done     <= 1'b0;
         Pass     <= 1'b0;
         ErrFlag  <= 1'b0;
         WrCount  <= 16'd0;
      end else begin
         if (state_q == S_IDLE && (MemWrite || MemRead)) begin
            adr_q   <= DataAdr;
            wdata_q <= WriteData;
            wr_q    <= MemWrite;
            rd_q    <= MemRead & ~MemWrite;
         end
         if (enter_resp) ReadData <= (acc_rd && !acc_bad) ? mem[acc_idx] : 32'd0;
         else if (state_q == S_RESP) ReadData <= 32'd0;
         if (enter_resp && acc_bad) ErrFlag <= 1'b1;
         if (do_write && WrCount != 16'hFFFF) WrCount <= WrCount + 16'd1;
         // Only the first mailbox write decides the verdict.
         if (do_write && acc_adr == 32'(CHECK_ADDR) && !Done) begin
            Done <= 1'b1;
            Pass <= (acc_wdata == 32'(CHECK_DATA));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) mem[acc_idx] <= acc_wdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against an array-based memory model,
// with extra zero- and three-wait-state instances for latency.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mw = 1'b0, mr = 1'b0;
   logic [31:0] adr = 32'd0, wd = 32'd0;

   logic [31:0] rd1, rd0, rd3;
   logic        rdy1, rdy0, rdy3, done1, done0, done3, pass1, pass0, pass3, err1, err0, err3;
   logic [15:0] wc1, wc0, wc3;
   logic [1:0]  st1, st0, st3;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_mem [64];
   bit          m_vld [64];
   bit          m_done, m_pass, m_err;
   int          m_wc;

   always #5 clk = ~clk;

   dmem_responder #(.WAIT_STATES(1)) dut (
      .clk(clk), .reset(reset), .MemWrite(mw), .MemRead(mr), .DataAdr(adr), .WriteData(wd),
      .ReadData(rd1), .Ready(rdy1), .Done(done1), .Pass(pass1), .ErrFlag(err1),
      .WrCount(wc1), .state_o(st1));

   dmem_responder #(.WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .reset(reset), .MemWrite(mw), .MemRead(mr), .DataAdr(adr), .WriteData(wd),
      .ReadData(rd0), .Ready(rdy0), .Done(done0), .Pass(pass0), .ErrFlag(err0),
      .WrCount(wc0), .state_o(st0));

   dmem_responder #(.WAIT_STATES(3)) dut_ws3 (
      .clk(clk), .reset(reset), .MemWrite(mw), .MemRead(mr), .DataAdr(adr), .WriteData(wd),
      .ReadData(rd3), .Ready(rdy3), .Done(done3), .Pass(pass3), .ErrFlag(err3),
      .WrCount(wc3), .state_o(st3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_done = 0; m_pass = 0; m_err = 0; m_wc = 0;
   endtask

   // Behavioural model of one access: returns the expected read data and whether it is defined.
   task automatic model_access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] exp_rd, output bit known);
      bit bad;
      int idx;
      bad = (a % 4 != 0) || (a >= 256);
      idx = int'(a / 4) % 64;
      exp_rd = 32'd0;
      known  = 1;
      if (bad) m_err = 1;
      if (w && !bad) begin
         m_mem[idx] = d;
         m_vld[idx] = 1;
         if (m_wc < 65535) m_wc++;
         if (a == 100 && !m_done) begin
            m_done = 1;
            m_pass = (d == 7);
         end
      end else if (r && !w && !bad) begin
         exp_rd = m_mem[idx];
         known  = m_vld[idx];
      end
   endtask

   // Holds the request until Ready; lat counts rising edges from capture to Ready.
   task automatic do_access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rdata, output int lat);
      mw = w; mr = r; adr = a; wd = d;
      lat = 0;
      rdata = 32'd0;
      while (lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (rdy1) break;
      end
      rdata = rd1;
      mw = 0; mr = 0;
   endtask

   task automatic txn(input string tag, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d);
      logic [31:0] exp_rd, got;
      bit known;
      int lat;
      model_access(w, r, a, d, exp_rd, known);
      do_access(w, r, a, d, got, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd2);
      if (known) chk({tag, "_rdata"}, got, exp_rd);
      chk({tag, "_done"}, 32'(done1), 32'(m_done));
      chk({tag, "_pass"}, 32'(pass1), 32'(m_pass));
      chk({tag, "_err"}, 32'(err1), 32'(m_err));
      chk({tag, "_wrcount"}, 32'(wc1), 32'(m_wc));
      @(negedge clk);
      chk({tag, "_rdata_clr"}, rd1, 32'd0);
      chk({tag, "_ready_clr"}, 32'(rdy1), 32'd0);
   endtask

   initial begin
      int lat0, lat1, lat3, n0, n1, n3;
      logic [31:0] a, d;
      int sel;
      bit w, r;

      for (int i = 0; i < 64; i++) m_vld[i] = 0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(rdy1), 32'd0);
      chk("rst_rdata", rd1, 32'd0);
      chk("rst_flags", {29'd0, done1, pass1, err1}, 32'd0);
      chk("rst_wrcount", 32'(wc1), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Latency for 0, 1 and 3 wait states from a single-edge read request
      lat0 = 0; lat1 = 0; lat3 = 0; n0 = 0; n1 = 0; n3 = 0;
      mr = 1; adr = 32'd0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         @(negedge clk);
         mr = 0;
         if (rdy0) begin n0++; if (lat0 == 0) lat0 = e; end
         if (rdy1) begin n1++; if (lat1 == 0) lat1 = e; end
         if (rdy3) begin n3++; if (lat3 == 0) lat3 = e; end
      end
      chk("lat_ws0", 32'(lat0), 32'd1);
      chk("lat_ws1", 32'(lat1), 32'd2);
      chk("lat_ws3", 32'(lat3), 32'd4);
      chk("ready_once_ws0", 32'(n0), 32'd1);
      chk("ready_once_ws1", 32'(n1), 32'd1);
      chk("ready_once_ws3", 32'(n3), 32'd1);

      txn("wr_20", 1, 0, 32'h20, 32'h12345678);
      txn("rd_20", 0, 1, 32'h20, 32'h0);
      txn("mbox_fail", 1, 0, 32'd100, 32'd5);

      // Reset pulsed while a write waits: no Ready, outputs cleared
      mw = 1; adr = 32'h10; wd = 32'hAA;
      @(posedge clk);
      @(negedge clk);
      chk("wait_no_ready", 32'(rdy1), 32'd0);
      reset = 1'b0;
      mw = 0;
      #1;
      chk("async_rst_flags", {29'd0, done1, pass1, err1}, 32'd0);
      chk("async_rst_wrcount", 32'(wc1), 32'd0);
      chk("async_rst_ready", 32'(rdy1), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      n1 = 0;
      repeat (4) begin
         @(negedge clk);
         if (rdy1) n1++;
      end
      chk("rst_discard_ready", 32'(n1), 32'd0);
      model_reset();
      m_vld[4] = 0;

      txn("mbox_pass", 1, 0, 32'd100, 32'd7);
      txn("mbox_rewrite", 1, 0, 32'd100, 32'd9);
      txn("mbox_read", 0, 1, 32'd100, 32'd0);
      txn("wr_misalign", 1, 0, 32'h22, 32'hDEADBEEF);
      txn("rd_oor", 0, 1, 32'h400, 32'd0);
      txn("wr_rd_both", 1, 1, 32'h30, 32'hCAFEF00D);
      txn("rd_30", 0, 1, 32'h30, 32'd0);

      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0) a = ($urandom_range(0, 63) << 2) | 32'($urandom_range(1, 3));
         else if (sel == 1) a = 32'd256 + ($urandom_range(0, 1023) << 2);
         else a = $urandom_range(0, 63) << 2;
         d = $urandom;
         sel = $urandom_range(0, 9);
         w = (sel < 4) || (sel == 9);
         r = (sel >= 4);
         txn("rand", w, r, a, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
